// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage register file and its scoreboard.
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int CNT_W_DEF = 2;

   localparam int REG_ZERO = 0;
   localparam int REG_A0   = 10;

   typedef logic [CNT_W_DEF-1:0] pend_cnt_t;

   function automatic int max_pend(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction
endpackage

// File: rtl/regfile_sb_counter.sv
// One register's outstanding-writer counter: up on issue, down on commit, clear on flush.
// Saturates at both ends and pulses err_o for the cycle an illegal step is attempted.
module sb_counter
   import regfile_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             err_o
);
   localparam logic [CNT_W-1:0] MAX_PEND = CNT_W'(max_pend(CNT_W));

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      err_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q == MAX_PEND) err_o = 1'b1;
         else                   cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) err_o = 1'b1;
         else             cnt_d = cnt_q - CNT_W'(1);
      end
      // A flush still reports an illegal step attempted in the same cycle.
      if (clr_i) cnt_d = '0;
   end

   always_ff @(posedge clock) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// N-read/1-write register file with a counting scoreboard; commit lands in the array next cycle,
// optionally bypassed to same-cycle reads. No backpressure: decode must stall on issue_full_o.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       decode_valid_post,
   input  logic                       decode_ready_post,
   input  logic                       decode_wena_i,
   input  logic [$clog2(NREGS)-1:0]   decode_waddr_i,
   output logic                       issue_full_o,
   input  logic                       commit_valid_i,
   input  logic                       commit_wena_i,
   input  logic [$clog2(NREGS)-1:0]   commit_waddr_i,
   input  logic [XLEN-1:0]            commit_wdata_i,
   input  logic                       flush_i,
   input  logic [NUM_RD-1:0]          rena_i,
   input  logic [NUM_RD*$clog2(NREGS)-1:0] raddr_i,
   output logic [NUM_RD*XLEN-1:0]     rdata_o,
   output logic [NUM_RD-1:0]          raw_vec_o,
   output logic                       raw_o,
   output logic                       sb_err_o
);
   localparam int AW = $clog2(NREGS);
   localparam logic [CNT_W-1:0] MAX_PEND = CNT_W'(max_pend(CNT_W));

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [CNT_W-1:0] cnt [NREGS];
   logic [NREGS-1:0] cnt_err;
   logic             err_q, err_d;
   logic             issue_ev, commit_ev;

   assign issue_ev  = decode_valid_post && decode_ready_post && decode_wena_i
                      && (decode_waddr_i != AW'(REG_ZERO));
   assign commit_ev = commit_valid_i && commit_wena_i && (commit_waddr_i != AW'(REG_ZERO));

   // x0 has no counter; it reads as permanently idle.
   assign cnt[0]     = '0;
   assign cnt_err[0] = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clock (clock),
         .reset (reset),
         .inc_i (issue_ev && (decode_waddr_i == AW'(r))),
         .dec_i (commit_ev && (commit_waddr_i == AW'(r))),
         .clr_i (flush_i),
         .cnt_o (cnt[r]),
         .err_o (cnt_err[r])
      );
   end

   always_comb begin
      regs_d = regs_q;
      if (commit_ev) regs_d[commit_waddr_i] = commit_wdata_i;
      regs_d[REG_ZERO] = '0;
      err_d = err_q || (|cnt_err);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      logic [AW-1:0] ra;
      logic          fwd;
      ra        = '0;
      fwd       = 1'b0;
      rdata_o   = '0;
      raw_vec_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra  = raddr_i[k*AW +: AW];
         fwd = (BYPASS != 0) && commit_ev && (commit_waddr_i == ra);
         if (rena_i[k] && (ra != AW'(REG_ZERO))) begin
            rdata_o[k*XLEN +: XLEN] = fwd ? commit_wdata_i : regs_q[ra];
            // A retiring last writer no longer blocks a bypassed read.
            raw_vec_o[k] = (cnt[ra] != '0) && !(fwd && (cnt[ra] == CNT_W'(1)));
         end
      end
   end

   assign raw_o        = |raw_vec_o;
   assign issue_full_o = decode_wena_i && (cnt[decode_waddr_i] == MAX_PEND);
   assign sb_err_o     = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: BYPASS=1 and BYPASS=0 instances share stimulus,
// expected outputs come from an array/integer reference model of the register file.
module tb_regfile_sb;
   localparam int XLEN = 32, NREGS = 32, NUM_RD = 2, CNT_W = 2, AW = 5;
   localparam int MAXP = 3;

   logic clock = 1'b1;
   logic reset;
   logic dv, dr, dw, cv, cw, fl;
   logic [AW-1:0] da, ca;
   logic [XLEN-1:0] cd;
   logic [NUM_RD-1:0] rena;
   logic [NUM_RD*AW-1:0] raddr;

   logic [NUM_RD*XLEN-1:0] rdata_b, rdata_nb;
   logic [NUM_RD-1:0] rawv_b, rawv_nb;
   logic raw_b, raw_nb, full_b, full_nb, err_b, err_nb;

   always #5 clock = ~clock;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .BYPASS(1)) dut (
      .clock(clock), .reset(reset),
      .decode_valid_post(dv), .decode_ready_post(dr), .decode_wena_i(dw), .decode_waddr_i(da),
      .issue_full_o(full_b),
      .commit_valid_i(cv), .commit_wena_i(cw), .commit_waddr_i(ca), .commit_wdata_i(cd),
      .flush_i(fl), .rena_i(rena), .raddr_i(raddr),
      .rdata_o(rdata_b), .raw_vec_o(rawv_b), .raw_o(raw_b), .sb_err_o(err_b));

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .BYPASS(0)) dut_nb (
      .clock(clock), .reset(reset),
      .decode_valid_post(dv), .decode_ready_post(dr), .decode_wena_i(dw), .decode_waddr_i(da),
      .issue_full_o(full_nb),
      .commit_valid_i(cv), .commit_wena_i(cw), .commit_waddr_i(ca), .commit_wdata_i(cd),
      .flush_i(fl), .rena_i(rena), .raddr_i(raddr),
      .rdata_o(rdata_nb), .raw_vec_o(rawv_nb), .raw_o(raw_nb), .sb_err_o(err_nb));

   typedef struct packed {
      logic [NUM_RD*XLEN-1:0] rd_b;
      logic [NUM_RD*XLEN-1:0] rd_nb;
      logic [NUM_RD-1:0]      rawv_b;
      logic [NUM_RD-1:0]      rawv_nb;
      logic                   full;
      logic                   err;
   } exp_t;

   exp_t exp_q[$];

   logic [XLEN-1:0] m_regs [NREGS];
   int              m_cnt  [NREGS];
   bit              m_err;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: the DUT's combinational outputs are valid every cycle; compare at the falling edge.
   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rdata_bypass",   rdata_b,  e.rd_b);
         check("rdata_nobypass", rdata_nb, e.rd_nb);
         check("raw_vec_bypass",   rawv_b,  e.rawv_b);
         check("raw_vec_nobypass", rawv_nb, e.rawv_nb);
         check("raw_bypass",   raw_b,  |e.rawv_b);
         check("raw_nobypass", raw_nb, |e.rawv_nb);
         check("issue_full_bypass",   full_b,  e.full);
         check("issue_full_nobypass", full_nb, e.full);
         check("sb_err_bypass",   err_b,  e.err);
         check("sb_err_nobypass", err_nb, e.err);
      end
   end

   function automatic void model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_regs[r] = '0;
         m_cnt[r]  = 0;
      end
      m_err = 0;
   endfunction

   // Predict this cycle's outputs, let the edge happen, then advance the model.
   task automatic step();
      exp_t e;
      bit commit_ev, issue_ev;
      int a;
      commit_ev = cv && cw && (ca != 0);
      issue_ev  = dv && dr && dw && (da != 0);
      e = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a = int'(raddr[k*AW +: AW]);
         if (rena[k] && a != 0) begin
            e.rd_nb[k*XLEN +: XLEN] = m_regs[a];
            e.rd_b[k*XLEN +: XLEN]  = (commit_ev && int'(ca) == a) ? cd : m_regs[a];
            e.rawv_nb[k] = (m_cnt[a] != 0);
            e.rawv_b[k]  = (m_cnt[a] != 0) && !(commit_ev && int'(ca) == a && m_cnt[a] == 1);
         end
      end
      e.full = dw && (m_cnt[da] == MAXP);
      e.err  = m_err;
      exp_q.push_back(e);

      @(posedge clock);
      if (!reset) begin
         model_reset();
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            bit inc, dec;
            inc = issue_ev && int'(da) == r;
            dec = commit_ev && int'(ca) == r;
            if (inc && !dec) begin
               if (m_cnt[r] == MAXP) m_err = 1;
               else                  m_cnt[r] += 1;
            end
            if (dec && !inc) begin
               if (m_cnt[r] == 0) m_err = 1;
               else               m_cnt[r] -= 1;
            end
            if (fl) m_cnt[r] = 0;
         end
         if (commit_ev) m_regs[ca] = cd;
      end
      #1;
   endtask

   task automatic idle();
      reset = 1'b1;
      dv = 0; dr = 0; dw = 0; da = '0;
      cv = 0; cw = 0; ca = '0; cd = '0;
      fl = 0; rena = '0; raddr = '0;
   endtask

   task automatic set_issue(input int a);
      dv = 1; dr = 1; dw = 1; da = AW'(a);
   endtask

   task automatic set_commit(input int a, input logic [XLEN-1:0] d);
      cv = 1; cw = 1; ca = AW'(a); cd = d;
   endtask

   task automatic set_rd(input int k, input int a);
      rena[k] = 1'b1;
      raddr[k*AW +: AW] = AW'(a);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      step();
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      reset = 1'b0;
      model_reset();
      @(posedge clock);
      #1;

      // Writes and issues while reset is held must leave everything clear.
      for (int i = 0; i < 2; i++) begin
         idle(); reset = 1'b0;
         set_issue(5); set_commit(5, 32'h1234); set_rd(0, 5); set_rd(1, 6);
         step();
      end
      idle(); set_rd(0, 5); set_rd(1, 5); step();
      idle(); set_commit(5, 32'h1234); step();
      idle(); set_rd(0, 5); step();

      // Two outstanding writers to x3.
      do_reset();
      idle(); set_issue(3); step();
      idle(); set_issue(3); set_rd(0, 3); step();
      idle(); set_commit(3, 32'hA); set_rd(0, 3); step();
      idle(); set_rd(0, 3); step();
      idle(); set_commit(3, 32'hB); set_rd(0, 3); step();
      idle(); set_rd(0, 3); step();

      // Commit-to-read bypass on x7 with a single pending writer.
      do_reset();
      idle(); set_issue(7); step();
      idle(); set_commit(7, 32'h1111); step();
      idle(); set_issue(7); step();
      idle(); set_commit(7, 32'hDEAD); set_rd(1, 7); set_rd(0, 7); step();
      idle(); set_rd(1, 7); step();

      // Same-cycle issue and commit: x4 keeps its count, x0 is inert.
      do_reset();
      idle(); set_issue(4); step();
      idle(); set_issue(4); set_commit(4, 32'h44); set_rd(0, 4); step();
      idle(); set_rd(0, 4); step();
      idle(); set_issue(0); set_commit(0, 32'hFFFF); set_rd(0, 0); step();
      idle(); set_rd(0, 0); set_rd(1, 4); step();

      // Saturation on x9, then underflow on x2.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle(); set_issue(9); set_rd(0, 9); step();
      end
      idle(); dw = 1; da = AW'(9); step();
      do_reset();
      idle(); set_commit(2, 32'h77); set_rd(0, 2); step();
      idle(); set_rd(0, 2); step();

      // Flush with a same-cycle commit keeps the data, clears the counts, keeps sb_err.
      do_reset();
      idle(); set_commit(6, 32'h6); step();
      idle(); set_issue(1); step();
      idle(); set_issue(1); step();
      idle(); set_issue(2); step();
      idle(); fl = 1; set_commit(1, 32'h55); set_rd(0, 1); set_rd(1, 2); step();
      idle(); set_rd(0, 1); set_rd(1, 2); step();

      // Randomised traffic concentrated on a few registers to provoke hazards.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         idle();
         reset = ($urandom_range(0, 199) != 0);
         dv = 1'($urandom); dr = 1'($urandom);
         dw = ($urandom_range(0, 3) != 0);
         da = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         cv = 1'($urandom);
         cw = ($urandom_range(0, 3) != 0);
         ca = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         cd = $urandom;
         fl = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < NUM_RD; k++) begin
            rena[k] = ($urandom_range(0, 4) != 0);
            raddr[k*AW +: AW] = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         end
         step();
      end

      idle();
      @(negedge clock);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
